apb_console_writer: RTL and testbench
=====================================

# apb_console_writer

APB requester that turns a byte stream into single-byte APB write transfers to the console address, the transmit-side counterpart of the simulation console sink. Bytes are accepted over a valid/ready port, buffered in a small FIFO, and written one per APB transfer to `CONSOLE_ADDR`. It sits in the test harness or debug subsystem wherever a non-CPU agent (boot ROM model, BIST, trace unit) must print to the console over the shared APB.

## Interface
Parameters:
- `CONSOLE_ADDR`, 32'h1000_0000: target address of every write.
- `FIFO_DEPTH`, 8: byte buffer depth; power of two, ≥ 2.
- `WAIT_MAX`, 255: maximum ACCESS cycles waiting for `pready_i` before the transfer is aborted; ≥ 1.

Ports:
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: a byte is offered.
- `in_data_i` in 8: byte to print.
- `in_ready_o` out 1: the byte is accepted when valid and ready are both high.
- `psel_o` out 1: APB select.
- `penable_o` out 1: APB enable.
- `pwrite_o` out 1: constant 1 while `psel_o`, else 0.
- `paddr_o` out 32: `CONSOLE_ADDR` while `psel_o`, else 0.
- `pwdata_o` out 32: {24'h0, byte} while `psel_o`, else 0.
- `pstrb_o` out 4: 4'b0001 while `psel_o`, else 0.
- `pready_i` in 1: completer ready.
- `pslverr_i` in 1: completer error, valid only with `pready_i`.
- `busy_o` out 1: FIFO is non-empty or the FSM is not IDLE.
- `sent_cnt_o` out 32: count of completed transfers with `pslverr_i` = 0; wraps.
- `err_cnt_o` out 16: count of slave-error plus timeout transfers; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP when the FIFO is non-empty.
  - SETUP → ACCESS unconditionally.
  - ACCESS stays in ACCESS while `pready_i` = 0 and the wait counter is below `WAIT_MAX`.
  - ACCESS ends when `pready_i` = 1 or on timeout. The FIFO head is then popped and the FSM goes to SETUP if more bytes remain (no idle cycle between transfers), else to IDLE.
- APB outputs are decoded from the state register: `psel_o` is high in SETUP and ACCESS; `penable_o` is high in ACCESS only.
- Data and address come from the registered FIFO head and are stable from SETUP through the end of ACCESS.
- Completion with `pslverr_i` = 1: the byte is dropped (no retry) and `err_cnt_o` increments.
- Timeout: the wait counter resets on entry to ACCESS and counts ACCESS cycles with `pready_i` = 0. When it reaches `WAIT_MAX`, the FSM leaves ACCESS on the next edge, the byte is dropped, and `err_cnt_o` increments.
- `in_ready_o` = FIFO not full. There is no bypass: when full, a pop in the same cycle does not admit a push.
- Push and pop in the same cycle with the FIFO neither empty nor full: occupancy is unchanged.

## Timing
- Reset values: all outputs 0 except `in_ready_o` = 1. FSM is IDLE, FIFO is empty, all counters are 0.
- Reset is asynchronous, so an assertion mid-transfer drops `psel_o` and `penable_o` immediately and discards buffered bytes.
- Latency: a byte accepted in cycle 0 gives SETUP in cycle 2 and ACCESS in cycle 3. With `pready_i` = 1 in cycle 3, the counters update at the end of cycle 3.
- Throughput: one byte per 2 cycles with zero-wait completer; one byte per 2 + N cycles with N wait states.
- Timeout with `WAIT_MAX` = W: ACCESS lasts exactly W cycles, then `psel_o` drops, or SETUP follows.
- `pready_i` and `pslverr_i` are ignored outside ACCESS.

## Structure
- Shared package (e.g. `console_pkg`) holds:
  - the `apb_state_e` enum (IDLE, SETUP, ACCESS);
  - the default `CONSOLE_ADDR`;
  - a byte-lane strobe constant.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): pointer-based with an extra wrap bit, and full/empty outputs. Reusable elsewhere.
- The top level contains the FSM, wait counter, and statistics counters.

## Test plan
- Reset then push "H" (8'h48) with zero-wait completer → SETUP in cycle 2 with `paddr_o` = 32'h1000_0000 and `pwdata_o` = 32'h48, then ACCESS in cycle 3; afterwards `sent_cnt_o` = 1 and `busy_o` = 0.
- Push 9 bytes back-to-back into `FIFO_DEPTH` = 8 with `pready_i` held low → `in_ready_o` deasserts once 8 are buffered. Release `pready_i` → 9 transfers in order with no idle cycle between them; `sent_cnt_o` = 9.
- Completer inserts 3 wait states on every transfer → each ACCESS lasts 4 cycles; address and data stay stable throughout.
- `pslverr_i` = 1 on the 2nd of 3 bytes → `err_cnt_o` = 1, `sent_cnt_o` = 2, and the 3rd byte is still sent.
- `WAIT_MAX` = 4 with `pready_i` held at 0 → ACCESS lasts exactly 4 cycles, then `err_cnt_o` = 1, the byte is dropped, and the FSM returns to IDLE.
- Assert `rst_ni` low mid-ACCESS with 5 bytes buffered → `psel_o` falls in the same cycle; after release, `busy_o` = 0 and the counters are 0.

Source files
------------

// File: rtl/apb_console_writer_pkg.sv
// Shared types and constants for the APB console writer and its helpers.
package apb_console_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;
    localparam logic [3:0]  BYTE_LANE_STRB       = 4'b0001;

endpackage

// File: rtl/apb_console_writer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read straight from the storage array.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_ok)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/apb_console_writer.sv
// Buffers a byte stream and writes each byte to the console address as one APB transfer.
module apb_console_writer
    import apb_console_writer_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned WAIT_MAX     = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // Byte port: a byte transfers on any rising edge where in_valid_i and in_ready_o are both high.
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        busy_o,
    output logic [31:0] sent_cnt_o,
    output logic [15:0] err_cnt_o,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX - 1);

    apb_state_e     state_q, state_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [31:0]    sent_q, sent_d;
    logic [15:0]    err_q, err_d;

    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_head;
    logic [LW-1:0]  fifo_level;
    logic           pop;
    logic           timeout;
    logic           more;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (in_valid_i),
        .wdata_i (in_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign in_ready_o = !fifo_full;
    assign timeout    = !pready_i && (wait_q == WAIT_LAST);
    // The head is still counted in the level while it is being written out.
    assign more       = fifo_level > LW'(1);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        sent_d  = sent_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = '0;
            end
            ACCESS: begin
                if (pready_i || timeout) begin
                    pop     = 1'b1;
                    state_d = more ? SETUP : IDLE;
                    if (pready_i && !pslverr_i) begin
                        sent_d = sent_q + 32'd1;
                    end else if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wait_q  <= '0;
            sent_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    assign psel_o      = (state_q != IDLE);
    assign penable_o   = (state_q == ACCESS);
    assign pwrite_o    = psel_o;
    assign paddr_o     = psel_o ? CONSOLE_ADDR : 32'h0;
    assign pwdata_o    = psel_o ? {24'h0, fifo_head} : 32'h0;
    assign pstrb_o     = psel_o ? BYTE_LANE_STRB : 4'h0;
    assign busy_o      = !fifo_empty || (state_q != IDLE);
    assign sent_cnt_o  = sent_q;
    assign err_cnt_o   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_console_writer.sv
// Directed bench for apb_console_writer: latency, back-pressure, wait states, errors, timeout, reset.
module tb_apb_console_writer;
    import apb_console_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, psel, penable, pwrite, pready, pslverr, busy;
    logic [7:0]  in_data;
    logic [31:0] paddr, pwdata, sent_cnt;
    logic [3:0]  pstrb;
    logic [15:0] err_cnt;
    logic [1:0]  dbg_state;

    logic        t_in_valid, t_in_ready, t_psel, t_penable, t_pwrite, t_busy;
    logic [7:0]  t_in_data;
    logic [31:0] t_paddr, t_pwdata, t_sent_cnt;
    logic [3:0]  t_pstrb;
    logic [15:0] t_err_cnt;
    logic [1:0]  t_dbg_state;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    apb_console_writer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .paddr_o(paddr), .pwdata_o(pwdata), .pstrb_o(pstrb),
        .pready_i(pready), .pslverr_i(pslverr),
        .busy_o(busy), .sent_cnt_o(sent_cnt), .err_cnt_o(err_cnt),
        .dbg_state_o(dbg_state)
    );

    apb_console_writer #(.WAIT_MAX(4)) dut_to (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(t_in_valid), .in_data_i(t_in_data), .in_ready_o(t_in_ready),
        .psel_o(t_psel), .penable_o(t_penable), .pwrite_o(t_pwrite),
        .paddr_o(t_paddr), .pwdata_o(t_pwdata), .pstrb_o(t_pstrb),
        .pready_i(1'b0), .pslverr_i(1'b0),
        .busy_o(t_busy), .sent_cnt_o(t_sent_cnt), .err_cnt_o(t_err_cnt),
        .dbg_state_o(t_dbg_state)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        in_valid   = 1'b0;
        in_data    = 8'h00;
        pready     = 1'b0;
        pslverr    = 1'b0;
        t_in_valid = 1'b0;
        t_in_data  = 8'h00;
        rst_n      = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !in_ready; k++) tick();
        check("push_ready", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int         psel_cycles, acc, done, xfer;
        logic       in_acc, stable, accept;
        logic [31:0] cur_d, cur_a;

        // Reset values
        do_reset();
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_psel", {31'h0, psel}, 32'h0);
        check("rst_penable", {31'h0, penable}, 32'h0);
        check("rst_pwrite", {31'h0, pwrite}, 32'h0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_pstrb", {28'h0, pstrb}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_sent", sent_cnt, 32'h0);
        check("rst_err", {16'h0, err_cnt}, 32'h0);

        // Single byte "H" with zero-wait completer
        pready   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h48;
        tick();
        in_valid = 1'b0;
        check("h_c1_psel", {31'h0, psel}, 32'h0);
        check("h_c1_busy", {31'h0, busy}, 32'h1);
        tick();
        check("h_c2_psel", {31'h0, psel}, 32'h1);
        check("h_c2_penable", {31'h0, penable}, 32'h0);
        check("h_c2_state", {30'h0, dbg_state}, {30'h0, SETUP});
        check("h_c2_paddr", paddr, 32'h1000_0000);
        check("h_c2_pwdata", pwdata, 32'h0000_0048);
        check("h_c2_pstrb", {28'h0, pstrb}, 32'h1);
        check("h_c2_pwrite", {31'h0, pwrite}, 32'h1);
        tick();
        check("h_c3_penable", {31'h0, penable}, 32'h1);
        check("h_c3_psel", {31'h0, psel}, 32'h1);
        tick();
        check("h_sent", sent_cnt, 32'd1);
        check("h_busy", {31'h0, busy}, 32'h0);
        check("h_psel_done", {31'h0, psel}, 32'h0);

        // Nine bytes against an eight-deep FIFO with the completer stalled
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
        check("bp_full", {31'h0, in_ready}, 32'h0);
        check("bp_stalled", {30'h0, dbg_state}, {30'h0, ACCESS});
        in_valid    = 1'b1;
        in_data     = 8'h38;
        pready      = 1'b1;
        psel_cycles = 0;
        for (int k = 0; k < 60 && psel; k++) begin
            psel_cycles++;
            if (penable) check("bp_data", pwdata, {24'h0, exp_q.pop_front()});
            accept = in_valid && in_ready;
            tick();
            if (accept) in_valid = 1'b0;
        end
        check("bp_psel_cycles", psel_cycles, 32'd17);
        check("bp_sent", sent_cnt, 32'd9);
        check("bp_left", exp_q.size(), 32'd0);
        check("bp_busy", {31'h0, busy}, 32'h0);

        // Three wait states on every transfer
        do_reset();
        exp_q.delete();
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        push_byte(8'hA1);
        push_byte(8'hA2);
        done   = 0;
        acc    = 0;
        in_acc = 1'b0;
        stable = 1'b1;
        cur_d  = '0;
        cur_a  = '0;
        for (int k = 0; k < 40 && done < 2; k++) begin
            if (in_acc && !(psel && penable)) begin
                check("ws_len", acc, 32'd4);
                check("ws_stable", {31'h0, stable}, 32'h1);
                done++;
            end
            in_acc = psel && penable;
            if (psel && !penable) begin
                cur_d  = pwdata;
                cur_a  = paddr;
                acc    = 0;
                stable = 1'b1;
            end
            if (in_acc) begin
                acc++;
                if (pwdata !== cur_d || paddr !== cur_a) stable = 1'b0;
                if (acc == 1) check("ws_data", pwdata, {24'h0, exp_q.pop_front()});
            end
            pready = in_acc && (acc == 4);
            tick();
        end
        pready = 1'b0;
        check("ws_done", done, 32'd2);
        check("ws_sent", sent_cnt, 32'd2);

        // Slave error on the second of three bytes
        do_reset();
        exp_q.delete();
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h63);
        pready = 1'b1;
        push_byte(8'h61);
        push_byte(8'h62);
        push_byte(8'h63);
        xfer = 0;
        for (int k = 0; k < 20; k++) begin
            if (psel && penable) begin
                xfer++;
                check("se_data", pwdata, {24'h0, exp_q.pop_front()});
                pslverr = (xfer == 2);
            end else begin
                pslverr = 1'b0;
            end
            tick();
        end
        pslverr = 1'b0;
        check("se_xfers", xfer, 32'd3);
        check("se_err", {16'h0, err_cnt}, 32'd1);
        check("se_sent", sent_cnt, 32'd2);

        // Timeout with WAIT_MAX = 4 and a completer that never answers
        do_reset();
        check("to_ready", {31'h0, t_in_ready}, 32'h1);
        t_in_valid = 1'b1;
        t_in_data  = 8'h5A;
        tick();
        t_in_valid = 1'b0;
        acc = 0;
        for (int k = 0; k < 30; k++) begin
            if (t_psel && t_penable) acc++;
            tick();
        end
        check("to_access_len", acc, 32'd4);
        check("to_err", {16'h0, t_err_cnt}, 32'd1);
        check("to_sent", t_sent_cnt, 32'd0);
        check("to_busy", {31'h0, t_busy}, 32'h0);
        check("to_state", {30'h0, t_dbg_state}, {30'h0, IDLE});

        // Asynchronous reset in the middle of an ACCESS phase
        do_reset();
        pready = 1'b1;
        push_byte(8'h11);
        repeat (4) tick();
        check("ar_pre_sent", sent_cnt, 32'd1);
        pready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h70 + 8'(i));
        check("ar_pre_access", {31'h0, penable}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_psel", {31'h0, psel}, 32'h0);
        check("ar_penable", {31'h0, penable}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_busy", {31'h0, busy}, 32'h0);
        check("ar_sent", sent_cnt, 32'd0);
        check("ar_err", {16'h0, err_cnt}, 32'd0);
        check("ar_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (3) tick();
        check("ar_stays_idle", {31'h0, psel}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
